// File: rtl/cpu_debug_panel_pkg.sv
// Shared definitions for the cpu debug panel: step FSM encodings and 7-segment glyphs.
// Glyphs are active-low {dp,g,f,e,d,c,b,a}; dp is always off.
package cpu_debug_panel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } step_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  function automatic logic [7:0] hex7seg(input logic [3:0] i_nib);
    logic [7:0] w_seg;
    case (i_nib)
      4'h0: w_seg = SEG_0;
      4'h1: w_seg = SEG_1;
      4'h2: w_seg = SEG_2;
      4'h3: w_seg = SEG_3;
      4'h4: w_seg = SEG_4;
      4'h5: w_seg = SEG_5;
      4'h6: w_seg = SEG_6;
      4'h7: w_seg = SEG_7;
      4'h8: w_seg = SEG_8;
      4'h9: w_seg = SEG_9;
      4'hA: w_seg = SEG_A;
      4'hB: w_seg = SEG_B;
      4'hC: w_seg = SEG_C;
      4'hD: w_seg = SEG_D;
      4'hE: w_seg = SEG_E;
      default: w_seg = SEG_F;
    endcase
    return w_seg;
  endfunction

endpackage

// File: rtl/cpu_debug_panel_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, counting debouncer, 1-cycle rise pulse.
// Level flips only after DEB_CYCLES consecutive samples that differ from it.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_rise;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_rise   <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/cpu_debug_panel.sv
// Front panel for the cpu debug port: single-step clock, view select, 8-digit hex display.
// All outputs are registered; the shown value is a snapshot so a frame never tears.
module cpu_debug_panel
  import cpu_debug_panel_pkg::*;
#(
  parameter int         DEB_CYCLES  = 1_000_000,
  parameter int         PULSE_CYC   = 4,
  parameter int         REFRESH_DIV = 100_000,
  parameter logic [3:0] SEL_RESET   = 4'd1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_step_btn,
  input  logic        i_sel_btn,
  input  logic [31:0] i_f,
  output logic        o_cpu_clk,
  output logic [3:0]  o_display,
  output logic [7:0]  o_an,
  output logic [7:0]  o_seg
);

  localparam int PW = $clog2(PULSE_CYC + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYC - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);

  logic          w_step_rise;
  logic          w_sel_rise;
  step_state_t   r_state;
  logic [PW-1:0] r_pcnt;
  logic          r_cpu_clk;
  logic [3:0]    r_display;
  logic [31:0]   r_snap;
  logic [RW-1:0] r_ref;
  logic [2:0]    r_idx;
  logic [7:0]    r_an;
  logic [7:0]    r_seg;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_step_btn), .o_rise(w_step_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sel_deb (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_sel_btn), .o_rise(w_sel_rise)
  );

  logic       w_leave_low;
  logic       w_ref_tc;
  logic       w_wrap;
  logic [2:0] w_idx_nxt;

  assign w_leave_low = (r_state == LOW) && (r_pcnt == P_LAST);
  assign w_ref_tc    = (r_ref == R_LAST);
  assign w_wrap      = w_ref_tc && (r_idx == 3'd7);
  assign w_idx_nxt   = r_idx + 3'd1;

  // Presses arriving mid-pulse are dropped: only IDLE looks at the rise pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_pcnt    <= '0;
      r_cpu_clk <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_step_rise) begin
            r_state   <= HIGH;
            r_cpu_clk <= 1'b1;
            r_pcnt    <= '0;
          end
        end
        HIGH: begin
          if (r_pcnt == P_LAST) begin
            r_state   <= LOW;
            r_cpu_clk <= 1'b0;
            r_pcnt    <= '0;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        LOW: begin
          if (r_pcnt == P_LAST) begin
            r_state <= IDLE;
            r_pcnt  <= '0;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cpu_clk <= 1'b0;
          r_pcnt    <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_display <= SEL_RESET;
      r_snap    <= '0;
    end else begin
      if (w_sel_rise) r_display <= r_display + 4'd1;
      if (w_leave_low || w_sel_rise || w_wrap) r_snap <= i_f;
    end
  end

  // At the frame wrap the snapshot is reloaded this same cycle, so digit 0 takes i_f directly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref <= '0;
      r_idx <= '0;
      r_an  <= 8'hFE;
      r_seg <= SEG_BLANK;
    end else if (w_ref_tc) begin
      r_ref <= '0;
      r_idx <= w_idx_nxt;
      r_an  <= ~(8'b1 << w_idx_nxt);
      r_seg <= hex7seg(w_wrap ? i_f[3:0] : r_snap[{w_idx_nxt, 2'b00} +: 4]);
    end else begin
      r_ref <= r_ref + 1'b1;
    end
  end

  assign o_cpu_clk = r_cpu_clk;
  assign o_display = r_display;
  assign o_an      = r_an;
  assign o_seg     = r_seg;

endmodule

// File: tb/tb_cpu_debug_panel.sv
// Randomized self-checking bench for cpu_debug_panel against a press-level reference model.
module tb_cpu_debug_panel;

  localparam int DEB = 4;
  localparam int PULSE = 2;
  localparam int REFR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_btn = 1'b0;
  logic        sel_btn = 1'b0;
  logic [31:0] f = 32'h0;
  logic        cpu_clk;
  logic [3:0]  display;
  logic [7:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int hi_run = 0;
  bit prev_cc = 1'b0;
  bit mid_rst = 1'b0;
  int exp_disp;

  // Standard hex glyphs, active-low {dp,g,f,e,d,c,b,a}, lowercase b and d.
  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  cpu_debug_panel #(
    .DEB_CYCLES(DEB), .PULSE_CYC(PULSE), .REFRESH_DIV(REFR), .SEL_RESET(4'd1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_step_btn(step_btn), .i_sel_btn(sel_btn), .i_f(f),
    .o_cpu_clk(cpu_clk), .o_display(display), .o_an(an), .o_seg(seg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cpu_clk edge counter and high-phase width monitor
  always @(negedge clk) begin
    if (cpu_clk && !prev_cc) rises++;
    if (cpu_clk) begin
      hi_run++;
    end else begin
      if (prev_cc && !mid_rst) check("cpu_clk_high_width", hi_run, PULSE);
      hi_run = 0;
    end
    prev_cc = cpu_clk;
  end

  task automatic press(input bit on_step, input bit on_sel, input int hold);
    @(negedge clk);
    step_btn = on_step;
    sel_btn  = on_sel;
    repeat (hold) @(negedge clk);
    step_btn = 1'b0;
    sel_btn  = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_disp = 1;
    @(negedge clk);
  endtask

  task automatic wait_an(input logic [7:0] tgt, input int budget, input string tag);
    int n = 0;
    while (an !== tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, an, tgt);
  endtask

  task automatic scan_digits(input logic [31:0] v, input int first, input string tag);
    logic [7:0] en;
    for (int d = first; d < 8; d++) begin
      en = ~(8'b1 << d);
      wait_an(en, 4 * REFR, {tag, "_an"});
      check({tag, "_seg"}, seg, glyph[v[4*d +: 4]]);
    end
  endtask

  task automatic scan_check(input logic [31:0] v, input string tag);
    int dwell = 0;
    wait_an(8'h7F, 10 * REFR, {tag, "_sync"});
    wait_an(8'hFE, 2 * REFR, {tag, "_an0"});
    check({tag, "_seg0"}, seg, glyph[v[3:0]]);
    while (an === 8'hFE && dwell < 4 * REFR) begin
      @(negedge clk);
      dwell++;
    end
    check({tag, "_dwell"}, dwell, REFR);
    scan_digits(v, 1, tag);
  endtask

  initial begin
    int r0;
    int op;
    int hold;
    logic [31:0] v1;
    logic [31:0] v2;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_disp = 1;
    @(negedge clk);
    check("rst_display", display, 4'd1);
    check("rst_cpu_clk", cpu_clk, 1'b0);
    check("rst_an", an, 8'hFE);
    check("rst_seg", seg, 8'hFF);

    r0 = rises;
    press(1'b1, 1'b0, 10);
    check("step_one_pulse", rises - r0, 1);

    r0 = rises;
    press(1'b1, 1'b0, 3);
    check("step_glitch", rises - r0, 0);

    // A one-cycle bounce inside a held press must not produce a second step.
    r0 = rises;
    @(negedge clk);
    step_btn = 1'b1;
    repeat (6) @(negedge clk);
    step_btn = 1'b0;
    @(negedge clk);
    step_btn = 1'b1;
    repeat (6) @(negedge clk);
    step_btn = 1'b0;
    repeat (14) @(negedge clk);
    check("step_bounce", rises - r0, 1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      press(1'b0, 1'b1, 6);
      exp_disp = (exp_disp + 1) % 16;
      check("sel_walk", display, exp_disp);
    end
    check("sel_wrap_end", display, 4'd1);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 4);
      f  = $urandom;
      hold = (op == 1 || op == 3) ? $urandom_range(1, 3) : $urandom_range(5, 10);
      r0 = rises;
      press(op == 0 || op == 1 || op == 4, op == 2 || op == 3 || op == 4, hold);
      if (op == 2 || op == 4) exp_disp = (exp_disp + 1) % 16;
      check("rand_rises", rises - r0, (op == 0 || op == 4) ? 1 : 0);
      check("rand_display", display, exp_disp);
    end

    f = 32'h1234_ABCD;
    scan_check(32'h1234_ABCD, "scan_fixed");
    v1 = $urandom;
    f = v1;
    scan_check(v1, "scan_rand");

    wait_an(8'hEF, 10 * REFR, "tear_sync");
    check("tear_seg4", seg, glyph[v1[19:16]]);
    v2 = ~v1;
    f = v2;
    scan_digits(v1, 5, "tear_old");
    scan_digits(v2, 0, "tear_new");

    @(negedge clk);
    step_btn = 1'b1;
    begin
      int n = 0;
      while (cpu_clk !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_pulse_high", cpu_clk, 1'b1);
    mid_rst = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_mid_cpu_clk", cpu_clk, 1'b0);
    check("rst_mid_display", display, 4'd1);
    check("rst_mid_an", an, 8'hFE);
    check("rst_mid_seg", seg, 8'hFF);
    step_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_disp = 1;
    repeat (12) @(negedge clk);
    mid_rst = 1'b0;
    r0 = rises;
    press(1'b1, 1'b0, 8);
    check("post_rst_step", rises - r0, 1);
    check("post_rst_display", display, exp_disp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
